// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyphs, special patterns
// and result class codes, common to the driver and the pattern reader.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CLS_W = 2;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyphs on segments g..a, dp excluded
  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  localparam logic [6:0] HEX_TABLE [16] = '{
    HEX_0, HEX_1, HEX_2, HEX_3, HEX_4, HEX_5, HEX_6, HEX_7,
    HEX_8, HEX_9, HEX_A, HEX_B, HEX_C, HEX_D, HEX_E, HEX_F
  };

  localparam logic [SEG_W-1:0] PAT_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] PAT_LAMP  = 8'hFF;

  localparam logic [CLS_W-1:0] CLS_DIGIT   = 2'd0;
  localparam logic [CLS_W-1:0] CLS_BLANK   = 2'd1;
  localparam logic [CLS_W-1:0] CLS_LAMP    = 2'd2;
  localparam logic [CLS_W-1:0] CLS_INVALID = 2'd3;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a segment pattern into hex value, decimal point and class.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic [VAL_W-1:0] value_o,
  output logic             dp_o,
  output logic [CLS_W-1:0] cls_o
);

  logic hit;

  // All-on and all-off win over the table, so 0xFF is lamp-test rather than "8."
  always_comb begin
    value_o = '0;
    dp_o    = 1'b0;
    cls_o   = CLS_INVALID;
    hit     = 1'b0;
    if (pat_i == PAT_LAMP) begin
      cls_o = CLS_LAMP;
    end else if (pat_i == PAT_BLANK) begin
      cls_o = CLS_BLANK;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (!hit && (pat_i[SEG_G:SEG_A] == HEX_TABLE[i])) begin
          hit     = 1'b1;
          value_o = VAL_W'(i);
          dp_o    = pat_i[SEG_DP];
          cls_o   = CLS_DIGIT;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_pattern_reader.sv
// Samples the segment bus, qualifies a pattern by stability, decodes it and
// presents each newly seen pattern on a valid/ready output with overrun flag.
module seg7_pattern_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [VAL_W-1:0] data_out,
  output logic             dp_out,
  output logic [CLS_W-1:0] cls,
  output logic             overrun
);

  typedef enum logic {ST_SETTLING = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q;
  logic [SEG_W-1:0] seg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEG_W-1:0] last_pat_q;
  logic             last_valid_q;
  logic             out_valid_q;
  logic [VAL_W-1:0] data_q;
  logic             dp_q;
  logic [CLS_W-1:0] cls_q;
  logic             overrun_q;

  logic             match;
  logic             hit;
  logic             repeat_pat;
  logic             report;
  logic [VAL_W-1:0] dec_value;
  logic             dec_dp;
  logic [CLS_W-1:0] dec_cls;

  seg7_pattern_decode u_decode (
    .pat_i   (seg_q),
    .value_o (dec_value),
    .dp_o    (dec_dp),
    .cls_o   (dec_cls)
  );

  // hit fires on the edge the match count first reaches STABLE_CYCLES
  always_comb begin
    match = (seg_in == seg_q);
    if (!match) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    hit        = match && (cnt_q == CNT_HIT);
    repeat_pat = last_valid_q && (seg_q == last_pat_q);
    report     = (state_q == ST_SETTLING) && hit && !repeat_pat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETTLING;
      seg_q        <= '0;
      cnt_q        <= '0;
      last_pat_q   <= '0;
      last_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      dp_q         <= 1'b0;
      cls_q        <= CLS_DIGIT;
      overrun_q    <= 1'b0;
    end else begin
      seg_q     <= seg_in;
      cnt_q     <= cnt_d;
      overrun_q <= 1'b0;

      case (state_q)
        ST_SETTLING: if (hit) state_q <= ST_LOCKED;
        ST_LOCKED:   if (!match) state_q <= ST_SETTLING;
        default:     state_q <= ST_SETTLING;
      endcase

      // A new result replaces any pending one; only an unconsumed one counts as overrun
      if (report) begin
        out_valid_q  <= 1'b1;
        data_q       <= dec_value;
        dp_q         <= dec_dp;
        cls_q        <= dec_cls;
        overrun_q    <= out_valid_q && !out_ready;
        last_pat_q   <= seg_q;
        last_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign dp_out    = dp_q;
  assign cls       = cls_q;
  assign overrun   = overrun_q;

endmodule
